// File: rtl/keypad_scanner.sv
// Scans a 4x4 hex keypad one row at a time, debounces presses and releases,
// and emits one key code per press plus a shift register of the last 8 codes.
module keypad_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  col,
   output logic [3:0]  row,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   output logic [31:0] digits
);

   localparam int DivW = $clog2(SCAN_DIV);
   localparam int CntW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] DsCount = CntW'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   state_t          state, stateNext;
   logic [3:0]      colMeta, cs;
   logic [DivW-1:0] divCnt;
   logic            tick;
   logic [3:0]      rowNext, rowRotated;
   logic [1:0]      rowIdx, colIdx, keyCol, keyColNext;
   logic [CntW-1:0] cnt, cntNext, rel, relNext;
   logic            accept;
   logic [3:0]      acceptCode;

   function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Two-flop synchroniser; idles high so no phantom press is seen after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         colMeta <= 4'b1111;
         cs      <= 4'b1111;
      end else begin
         colMeta <= col;
         cs      <= colMeta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         divCnt <= '0;
      end else if (tick) begin
         divCnt <= '0;
      end else begin
         divCnt <= divCnt + 1'b1;
      end
   end

   assign tick       = (divCnt == DivLast);
   assign rowRotated = {row[2:0], row[3]};

   always_comb begin
      rowIdx = 2'd0;
      case (row)
         4'b1101: rowIdx = 2'd1;
         4'b1011: rowIdx = 2'd2;
         4'b0111: rowIdx = 2'd3;
         default: rowIdx = 2'd0;
      endcase
   end

   // Lowest-numbered active column wins when several are low
   always_comb begin
      if (!cs[0])      colIdx = 2'd0;
      else if (!cs[1]) colIdx = 2'd1;
      else if (!cs[2]) colIdx = 2'd2;
      else             colIdx = 2'd3;
   end

   always_comb begin
      stateNext  = state;
      rowNext    = row;
      keyColNext = keyCol;
      cntNext    = cnt;
      relNext    = rel;
      accept     = 1'b0;
      if (tick) begin
         case (state)
            SCAN: begin
               if (cs == 4'b1111) begin
                  rowNext = rowRotated;
               end else begin
                  keyColNext = colIdx;
                  cntNext    = CntW'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     accept    = 1'b1;
                     relNext   = '0;
                     stateNext = HELD;
                  end else begin
                     stateNext = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (cs != 4'b1111 && colIdx == keyCol) begin
                  cntNext = cnt + 1'b1;
                  if (cnt + 1'b1 == DsCount) begin
                     accept    = 1'b1;
                     relNext   = '0;
                     stateNext = HELD;
                  end
               end else begin
                  cntNext   = '0;
                  rowNext   = rowRotated;
                  stateNext = SCAN;
               end
            end
            HELD: begin
               if (cs == 4'b1111) begin
                  if (rel + 1'b1 == DsCount) begin
                     relNext   = '0;
                     cntNext   = '0;
                     rowNext   = rowRotated;
                     stateNext = SCAN;
                  end else begin
                     relNext = rel + 1'b1;
                  end
               end else begin
                  relNext = '0;
               end
            end
            default: stateNext = SCAN;
         endcase
      end
   end

   assign acceptCode = keyMap(rowIdx, keyColNext);
   assign key_held   = (state == HELD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SCAN;
         row       <= 4'b1110;
         keyCol    <= 2'd0;
         cnt       <= '0;
         rel       <= '0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         digits    <= 32'h0;
      end else begin
         state     <= stateNext;
         row       <= rowNext;
         keyCol    <= keyColNext;
         cnt       <= cntNext;
         rel       <= relNext;
         key_valid <= accept;
         if (accept) begin
            key_code <= acceptCode;
            digits   <= {digits[27:0], acceptCode};
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a simulated key matrix driven by
// directed and random presses, compared tick by tick against a behavioural model.
module tb_keypad_scanner;

   localparam int ScanDiv  = 4;
   localparam int Debounce = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  col, row, key_code;
   logic        key_valid, key_held;
   logic [31:0] digits;

   logic [15:0] keysDown;
   int checksTotal  = 0;
   int checksPassed = 0;
   int validPulses  = 0;

   int         mRow, mMode, mCnt, mRel, mCol, mAccepts;
   logic [3:0] mCode;
   logic       mValid;
   logic [3:0] history[$];

   logic [3:0] keyTable [0:3][0:3] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'h0, 4'hF, 4'hE, 4'hD}};

   keypad_scanner #(.SCAN_DIV(ScanDiv), .DEBOUNCE_SCANS(Debounce)) dut (
      .clk(clk), .reset(reset), .col(col), .row(row), .key_code(key_code),
      .key_valid(key_valid), .key_held(key_held), .digits(digits));

   always #5 clk = ~clk;

   // Passive key matrix: a pressed key shorts its row line onto its column line
   always_comb begin
      col = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row[r] && keysDown[r*4+c]) col[c] = 1'b0;
   end

   always @(negedge clk) if (key_valid) validPulses++;

   initial begin
      #1000000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checksTotal++;
      if (observed === expected) checksPassed++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
   endtask

   function automatic logic [15:0] keyBit(input int r, input int c);
      return 16'(1) << (r*4 + c);
   endfunction

   function automatic logic [31:0] expDigits();
      logic [31:0] d = 32'h0;
      int n = history.size();
      for (int i = 0; i < 8; i++)
         if (i < n) d[4*i +: 4] = history[n-1-i];
      return d;
   endfunction

   function automatic logic [3:0] expRow();
      return ~(4'b0001 << mRow);
   endfunction

   task automatic modelReset();
      mRow = 0; mMode = 0; mCnt = 0; mRel = 0; mCol = 0;
      mCode = 4'h0; mValid = 1'b0;
      history.delete();
   endtask

   task automatic acceptKey();
      mMode  = 2;
      mRel   = 0;
      mCode  = keyTable[mRow][mCol];
      mValid = 1'b1;
      mAccepts++;
      history.push_back(mCode);
   endtask

   // One scan tick of the keypad's behaviour: mode 0 scanning, 1 debouncing, 2 held
   task automatic modelTick();
      int low = -1;
      for (int c = 3; c >= 0; c--)
         if (keysDown[mRow*4+c]) low = c;
      mValid = 1'b0;
      case (mMode)
         0: if (low < 0) mRow = (mRow + 1) % 4;
            else begin
               mCol = low; mCnt = 1;
               if (mCnt >= Debounce) acceptKey(); else mMode = 1;
            end
         1: if (low >= 0 && low == mCol) begin
               mCnt++;
               if (mCnt >= Debounce) acceptKey();
            end else begin
               mMode = 0; mRow = (mRow + 1) % 4;
            end
         default:
            if (low < 0) begin
               mRel++;
               if (mRel >= Debounce) begin mMode = 0; mRow = (mRow + 1) % 4; end
            end else mRel = 0;
      endcase
   endtask

   task automatic stepTick();
      for (int k = 1; k <= ScanDiv; k++) begin
         @(posedge clk); #1;
         if (k < ScanDiv) begin
            checkOutput("row_between_ticks", row, expRow());
            checkOutput("valid_between_ticks", key_valid, 1'b0);
         end
      end
      modelTick();
      checkOutput("row", row, expRow());
      checkOutput("key_valid", key_valid, mValid);
      checkOutput("key_held", key_held, mMode == 2);
      checkOutput("key_code", key_code, mCode);
      checkOutput("digits", digits, expDigits());
   endtask

   task automatic applyStimulus(input logic [15:0] keys, input int ticks);
      keysDown = keys;
      repeat (ticks) stepTick();
   endtask

   int pulsesBefore;
   logic [31:0] digitsBefore;
   logic [15:0] rnd;

   initial begin
      mAccepts = 0;
      modelReset();
      keysDown = 16'h0;
      reset = 1'b1;
      #12;
      checkOutput("reset_row", row, 4'b1110);
      checkOutput("reset_code", key_code, 4'h0);
      checkOutput("reset_valid", key_valid, 1'b0);
      checkOutput("reset_held", key_held, 1'b0);
      checkOutput("reset_digits", digits, 32'h0);
      @(negedge clk) reset = 1'b0;

      applyStimulus(16'h0, 8);

      pulsesBefore = validPulses;
      applyStimulus(keyBit(1, 1), 12);
      checkOutput("t2_code", key_code, 4'h5);
      checkOutput("t2_digits", digits, 32'h00000005);
      checkOutput("t2_held", key_held, 1'b1);
      checkOutput("t2_one_pulse", validPulses - pulsesBefore, 1);
      applyStimulus(16'h0, 6);

      for (int i = 0; i < 8 && mRow != 0; i++) applyStimulus(16'h0, 1);
      pulsesBefore = validPulses;
      digitsBefore = digits;
      applyStimulus(keyBit(0, 3), 2);
      applyStimulus(16'h0, 6);
      checkOutput("t3_no_pulse", validPulses - pulsesBefore, 0);
      checkOutput("t3_digits", digits, digitsBefore);

      pulsesBefore = validPulses;
      applyStimulus(keyBit(0, 3), 20);
      checkOutput("t4_held", key_held, 1'b1);
      applyStimulus(16'h0, 3);
      checkOutput("t4_released", key_held, 1'b0);
      checkOutput("t4_one_pulse", validPulses - pulsesBefore, 1);
      applyStimulus(16'h0, 2);

      for (int n = 0; n < 9; n++) begin
         applyStimulus(keyBit(n / 3, n % 3), 8);
         applyStimulus(16'h0, 4);
      end
      checkOutput("t5_digits", digits, 32'h23456789);

      applyStimulus(keyBit(2, 1) | keyBit(2, 3), 8);
      checkOutput("t6_code", key_code, 4'h8);
      applyStimulus(16'h0, 4);

      for (int i = 0; i < 40; i++) begin
         rnd = keyBit($urandom_range(0, 3), $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) rnd |= keyBit($urandom_range(0, 3), $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) rnd = 16'h0;
         applyStimulus(rnd, $urandom_range(1, 9));
         applyStimulus(16'h0, $urandom_range(0, 5));
      end
      applyStimulus(16'h0, 4);

      applyStimulus(keyBit(0, 0), 10);
      checkOutput("t7_held_before", key_held, 1'b1);
      #1 reset = 1'b1;
      #1;
      checkOutput("t7_row", row, 4'b1110);
      checkOutput("t7_held", key_held, 1'b0);
      checkOutput("t7_digits", digits, 32'h0);
      checkOutput("t7_code", key_code, 4'h0);
      keysDown = 16'h0;
      @(negedge clk) reset = 1'b0;
      modelReset();
      applyStimulus(16'h0, 4);
      applyStimulus(keyBit(3, 2), 8);
      applyStimulus(16'h0, 4);

      checkOutput("pulse_total", validPulses, mAccepts);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
